flow_bus_serializer_var: RTL and testbench
==========================================

Name: flow_bus_serializer_var

Overview:
Parametrised successor to the fixed-ratio bus serializer. It takes one wide word of DATA_NUM lanes per up-stream handshake and emits those lanes one per down-stream handshake. Each word carries its own lane count, so partial words are supported. Lane order is selectable, and packet framing (first/last) is carried through. It sits between wide producers (FIFO/DMA side) and narrow flow-bus consumers, and fully supports backpressure.

Parameters:
DATA_WIDTH, 8, width of one lane in bits
DATA_NUM, 4, lanes per up-stream word (>=2)
CNT_WIDTH, 3, width of up_count; must be >= clog2(DATA_NUM+1)
MSB_FIRST, 0, 0 = lane 0 (bits DATA_WIDTH-1:0) sent first; 1 = top lane sent first
USE_ENABLE, 1, 1 = enable input gates word acceptance; 0 = enable ignored

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
enable  in  1  when low (and USE_ENABLE=1), no new word is accepted
up_valid  in  1  up-stream word valid
up_ready  out  1  up-stream word accepted when up_valid & up_ready
up_data  in  DATA_WIDTH*DATA_NUM  wide word
up_count  in  CNT_WIDTH  lanes to emit; 0 or >DATA_NUM means DATA_NUM
up_last  in  1  word ends a packet
down_valid  out  1  lane valid
down_ready  in  1  lane consumed when down_valid & down_ready
down_data  out  DATA_WIDTH  current lane
down_first  out  1  current lane is lane 0 of its word
down_last  out  1  current lane is the final emitted lane of a word that had up_last=1
busy  out  1  a word is held (state SHIFT)

Behaviour:
- Reset (async assert, sync release): state IDLE, holding register 0, lane index 0, effective count 0, held last flag 0. Outputs: down_valid=0, down_data=0, down_first=0, down_last=0, busy=0. up_ready=1 if enable (or USE_ENABLE=0), else 0.
- Reset mid-word: the held word is discarded; no further lanes from it are emitted.
- States:
  - IDLE: down_valid=0. up_ready = en_eff, where en_eff = enable | ~USE_ENABLE.
  - SHIFT: down_valid=1. Data comes from holding register lane sel(idx). sel = idx if MSB_FIRST=0, DATA_NUM-1-idx if MSB_FIRST=1.
- Accept in IDLE: up_valid & up_ready. Register up_data, the effective count n (clamped as above) and up_last. Set idx=0 and go to SHIFT.
- Latency: first lane is visible on down_data the cycle after acceptance (registered output, no combinational up->down path).
- SHIFT transfer (down_valid & down_ready):
  - If idx < n-1: idx++.
  - If idx == n-1 (final lane): go to IDLE, unless up_valid & en_eff in the same cycle. In that case load the new word, set idx=0 and stay in SHIFT (no bubble).
- up_ready in SHIFT = en_eff & down_ready & (idx == n-1). This is combinational from down_ready, which is the only comb path.
- Steady-state throughput: one lane per cycle. A full word takes n cycles with no idle gap between back-to-back words.
- down_first = SHIFT & idx==0. down_last = SHIFT & idx==n-1 & held_last.
- down_valid, once high, never drops until transferred. down_data, down_first and down_last are stable while down_valid & ~down_ready.
- enable low during SHIFT: the current word drains normally; only the next acceptance is blocked.
- n=1: the word emits a single lane. down_first and (if up_last) down_last are both 1 on that lane.
- up_valid while up_ready=0: ignored. The up-stream must hold the word.
- Lanes at index >= n in the held word are never emitted.

Test Plan:
- DATA_NUM=4, MSB_FIRST=0, down_ready=1. Word 32'hDDCCBBAA, count 0, last 1 -> down_data AA,BB,CC,DD on 4 consecutive cycles; first on AA, last on DD; up_ready high only in the DD cycle.
- Same word with MSB_FIRST=1 -> DD,CC,BB,AA; down_last on AA.
- Back-to-back words 32'h04030201 (count 4) then 32'h0000_0605 (count 2, last) with up_valid held -> 01,02,03,04,05,06 with no gap; down_last only on 06.
- down_ready toggles 1,0,0,1,... -> each lane held stable while stalled; no lane lost or duplicated; total 4 transfers per word.
- enable=0 with up_valid=1 in IDLE -> up_ready=0, down_valid stays 0. enable dropped mid-word -> remaining lanes drain, then IDLE with up_ready=0.
- rst pulsed after 2 lanes of 32'hDDCCBBAA -> down_valid=0 asynchronously; CC,DD never appear; the next word starts cleanly from lane 0.

Source files
------------

// File: rtl/flow_bus_serializer_var.sv
// Wide-to-narrow flow-bus serializer: one DATA_NUM-lane word in, up to DATA_NUM lanes out,
// with a per-word lane count, selectable lane order and first/last framing.
module flow_bus_serializer_var #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_NUM   = 4,
    parameter int CNT_WIDTH  = 3,
    parameter int MSB_FIRST  = 0,
    parameter int USE_ENABLE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           up_valid,
    output logic                           up_ready,
    input  logic [DATA_WIDTH*DATA_NUM-1:0] up_data,
    input  logic [CNT_WIDTH-1:0]           up_count,
    input  logic                           up_last,
    output logic                           down_valid,
    input  logic                           down_ready,
    output logic [DATA_WIDTH-1:0]          down_data,
    output logic                           down_first,
    output logic                           down_last,
    output logic                           busy
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                          state;
    logic [DATA_WIDTH*DATA_NUM-1:0]  hold;
    logic [CNT_WIDTH-1:0]            idx;
    logic [CNT_WIDTH-1:0]            n_eff;
    logic                            held_last;

    logic                            en_eff;
    logic                            final_lane;
    logic                            accept;
    logic [CNT_WIDTH-1:0]            up_n;
    logic [CNT_WIDTH-1:0]            idx_next;

    assign en_eff     = enable | (USE_ENABLE == 0);
    assign final_lane = (idx == n_eff - CNT_WIDTH'(1));
    assign idx_next   = idx + CNT_WIDTH'(1);

    // A new word can land while the last lane of the current one is leaving, so back-to-back
    // words stream without a bubble; down_ready is the only combinational input here.
    assign up_ready = en_eff & ((state == IDLE) | ((state == SHIFT) & down_ready & final_lane));
    assign accept   = up_valid & up_ready;

    assign up_n = ((up_count == '0) || (up_count > CNT_WIDTH'(DATA_NUM)))
                  ? CNT_WIDTH'(DATA_NUM) : up_count;

    function automatic logic [DATA_WIDTH-1:0] lane(
        input logic [DATA_WIDTH*DATA_NUM-1:0] word,
        input logic [CNT_WIDTH-1:0]           i
    );
        int sel;
        sel = (MSB_FIRST != 0) ? (DATA_NUM - 1 - int'(i)) : int'(i);
        return word[sel*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    // Outputs are registered and computed one step ahead from the lane about to be presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold       <= '0;
            idx        <= '0;
            n_eff      <= '0;
            held_last  <= 1'b0;
            down_valid <= 1'b0;
            down_data  <= '0;
            down_first <= 1'b0;
            down_last  <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            hold       <= up_data;
            idx        <= '0;
            n_eff      <= up_n;
            held_last  <= up_last;
            down_valid <= 1'b1;
            down_data  <= lane(up_data, '0);
            down_first <= 1'b1;
            down_last  <= up_last & (up_n == CNT_WIDTH'(1));
            busy       <= 1'b1;
        end else if ((state == SHIFT) && down_ready) begin
            if (!final_lane) begin
                idx        <= idx_next;
                down_data  <= lane(hold, idx_next);
                down_first <= 1'b0;
                down_last  <= held_last & (idx_next == n_eff - CNT_WIDTH'(1));
            end else begin
                state      <= IDLE;
                down_valid <= 1'b0;
                down_data  <= '0;
                down_first <= 1'b0;
                down_last  <= 1'b0;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flow_bus_serializer_var.sv
// Bench for flow_bus_serializer_var: LSB-first and MSB-first instances share one stimulus stream
// and are compared against a queue of expected lanes built from each accepted word.
module tb_flow_bus_serializer_var;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        up_valid;
    logic [31:0] up_data;
    logic [2:0]  up_count;
    logic        up_last;
    logic        down_ready;

    logic        up_ready, down_valid, down_first, down_last, busy;
    logic [7:0]  down_data;
    logic        m_up_ready, m_down_valid, m_down_first, m_down_last, m_busy;
    logic [7:0]  m_down_data;

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       first;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  model_accept;

    always #5 clk = ~clk;

    flow_bus_serializer_var #(.DATA_WIDTH(8), .DATA_NUM(4), .CNT_WIDTH(3), .MSB_FIRST(0), .USE_ENABLE(1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data), .up_count(up_count), .up_last(up_last),
        .down_valid(down_valid), .down_ready(down_ready), .down_data(down_data),
        .down_first(down_first), .down_last(down_last), .busy(busy)
    );

    flow_bus_serializer_var #(.DATA_WIDTH(8), .DATA_NUM(4), .CNT_WIDTH(3), .MSB_FIRST(1), .USE_ENABLE(1)) dut_msb (
        .clk(clk), .rst(rst), .enable(enable),
        .up_valid(up_valid), .up_ready(m_up_ready), .up_data(up_data), .up_count(up_count), .up_last(up_last),
        .down_valid(m_down_valid), .down_ready(down_ready), .down_data(m_down_data),
        .down_first(m_down_first), .down_last(m_down_last), .busy(m_busy)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic exp_valid;
        logic exp_ready;
        exp_valid = (q.size() > 0);
        exp_ready = enable && ((q.size() == 0) || (down_ready && q.size() == 1));
        cmp("down_valid", 32'(down_valid), 32'(exp_valid));
        cmp("busy", 32'(busy), 32'(exp_valid));
        cmp("up_ready", 32'(up_ready), 32'(exp_ready));
        cmp("down_first", 32'(down_first), exp_valid ? 32'(q[0].first) : 32'd0);
        cmp("down_last", 32'(down_last), exp_valid ? 32'(q[0].last) : 32'd0);
        cmp("msb_down_valid", 32'(m_down_valid), 32'(exp_valid));
        cmp("msb_up_ready", 32'(m_up_ready), 32'(exp_ready));
        if (exp_valid) begin
            cmp("down_data", 32'(down_data), 32'(q[0].lsb));
            cmp("msb_down_data", 32'(m_down_data), 32'(q[0].msb));
            cmp("msb_down_last", 32'(m_down_last), 32'(q[0].last));
        end
    endtask

    task automatic pushWord(input logic [31:0] d, input logic [2:0] c, input logic l);
        int n;
        beat_t b;
        n = (c == 3'd0 || c > 3'd4) ? 4 : int'(c);
        for (int i = 0; i < n; i++) begin
            b.lsb   = d[8*i +: 8];
            b.msb   = d[8*(3-i) +: 8];
            b.first = (i == 0);
            b.last  = l && (i == n - 1);
            q.push_back(b);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, check, then advance the model at the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [2:0] c,
                                 input logic l, input logic en, input logic dr);
        logic pop;
        @(negedge clk);
        up_valid   = v;
        up_data    = d;
        up_count   = c;
        up_last    = l;
        enable     = en;
        down_ready = dr;
        #1;
        checkOutput();
        model_accept = up_valid && enable && ((q.size() == 0) || (down_ready && q.size() == 1));
        pop = (q.size() > 0) && down_ready;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (model_accept) pushWord(up_data, up_count, up_last);
    endtask

    task automatic sendWord(input logic [31:0] d, input logic [2:0] c, input logic l,
                            input logic en, input logic dr);
        int k = 0;
        do begin
            applyStimulus(1'b1, d, c, l, en, dr);
            k++;
        end while (!model_accept && k < 64);
        if (!model_accept) cmp("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n, input logic en);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, en, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; up_valid = 1'b0; up_data = '0; up_count = '0;
        up_last = 1'b0; down_ready = 1'b1; model_accept = 1'b0;
        #12;
        checkOutput();
        enable = 1'b0;
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;

        // Full word, both lane orders, last on the final lane
        sendWord(32'hDDCCBBAA, 3'd0, 1'b1, 1'b1, 1'b1);
        idleCycles(5, 1'b1);

        // Back-to-back words with up_valid held: no gap between them
        sendWord(32'h04030201, 3'd4, 1'b0, 1'b1, 1'b1);
        sendWord(32'h00000605, 3'd2, 1'b1, 1'b1, 1'b1);
        idleCycles(3, 1'b1);

        // Stalls on the down side
        sendWord(32'h44332211, 3'd0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, (i % 3) == 0);
        idleCycles(2, 1'b1);

        // Single-lane word and clamped count
        sendWord(32'h000000EE, 3'd1, 1'b1, 1'b1, 1'b1);
        sendWord(32'h98765432, 3'd6, 1'b1, 1'b1, 1'b1);
        idleCycles(5, 1'b1);

        // Enable low in IDLE blocks acceptance; low mid-word lets the word drain
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hCAFEF00D, 3'd0, 1'b1, 1'b0, 1'b1);
        sendWord(32'h55667788, 3'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'h12345678, 3'd0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-word discards the rest of the word
        sendWord(32'hDDCCBBAA, 3'd0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        sendWord(32'hA3A2A1A0, 3'd3, 1'b1, 1'b1, 1'b1);
        idleCycles(4, 1'b1);

        // Randomised traffic against the lane-queue model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0);
        end
        idleCycles(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
